ami_stream_reader: RTL

Synthesizable AMI read initiator. It accepts a command (base address, beat count) and issues 64-byte AMI read requests on the request/grant channel. It collects in-order responses on the response/grant channel, buffers them in an internal FIFO, and presents them as a valid/ready stream with a last-beat marker. It feeds DNNWeaver-side consumers and driver logic in place of file-backed memory responses.

---
 rtl/ami_stream_reader.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/ami_stream_reader.sv
// AMI read initiator: turns a (base address, beat count) command into 64-byte read
// requests and streams the in-order responses out through a credit-protected FIFO.
module ami_stream_reader #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 512,
    parameter int SIZE_W     = 7,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [CNT_W-1:0]  cmd_count,
    output logic              req_valid,
    output logic              req_is_write,
    output logic [ADDR_W-1:0] req_addr,
    output logic [SIZE_W-1:0] req_size,
    output logic [DATA_W-1:0] req_data,
    input  logic              req_grant,
    input  logic              resp_valid,
    input  logic [DATA_W-1:0] resp_data,
    input  logic [SIZE_W-1:0] resp_size,
    output logic              resp_grant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [SIZE_W-1:0] BEAT_BYTES = SIZE_W'(64);
    localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(64);
    localparam logic [ADDR_W-1:0] ADDR_LOW   = ADDR_W'(63);
    localparam logic [OCC_W:0]    DEPTH_EXT  = (OCC_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_W-1:0]     r_req_addr;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      r_issued;
    logic [CNT_W-1:0]      r_received;
    logic [OCC_W-1:0]      r_outstanding;
    logic [OCC_W-1:0]      r_occ;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [DATA_W-1:0]     r_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_last_mem;
    logic                  r_done;
    logic                  r_err;

    logic w_accept;
    logic w_credit_ok;
    logic w_req_valid;
    logic w_req_fire;
    logic w_resp_ok;
    logic w_push;
    logic w_push_last;
    logic w_pop;
    logic w_bad_resp;
    logic w_done_set;

    // Slots already promised (buffered + in flight) must leave room for every new request.
    assign w_accept    = (r_state == S_IDLE) && cmd_valid;
    assign w_credit_ok = ({1'b0, r_occ} + {1'b0, r_outstanding}) < DEPTH_EXT;
    assign w_req_valid = (r_state == S_RUN) && (r_issued < r_count) && w_credit_ok;
    assign w_req_fire  = w_req_valid && req_grant;
    assign w_resp_ok   = (r_state != S_IDLE) && (r_outstanding != OCC_W'(0));
    assign w_push      = resp_valid && w_resp_ok;
    assign w_push_last = (r_received == (r_count - CNT_W'(1)));
    assign w_pop       = (r_occ != OCC_W'(0)) && out_ready;
    assign w_bad_resp  = resp_valid && (!w_resp_ok || (resp_size != BEAT_BYTES));

    // Next-state and completion-pulse decode.
    always_comb begin
        w_state_next = r_state;
        w_done_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_count != CNT_W'(0)) begin
                        w_state_next = S_RUN;
                    end else begin
                        w_done_set = 1'b1;
                    end
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_issued == r_count) begin
                    w_state_next = S_DRAIN;
                end else begin
                    w_state_next = S_RUN;
                end
            end
            S_DRAIN: begin
                if ((r_received == r_count) && (r_occ == OCC_W'(0))) begin
                    w_state_next = S_IDLE;
                    w_done_set   = 1'b1;
                end else begin
                    w_state_next = S_DRAIN;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register plus done pulse and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_set;
            r_err   <= r_err | w_bad_resp;
        end
    end

    // Command latch, request address walk and issue/receive counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_addr <= ADDR_W'(0);
            r_count    <= CNT_W'(0);
            r_issued   <= CNT_W'(0);
            r_received <= CNT_W'(0);
        end else if (w_accept) begin
            r_req_addr <= cmd_addr & ~ADDR_LOW;
            r_count    <= cmd_count;
            r_issued   <= CNT_W'(0);
            r_received <= CNT_W'(0);
        end else begin
            if (w_req_fire) begin
                r_req_addr <= r_req_addr + ADDR_STEP;
                r_issued   <= r_issued + CNT_W'(1);
            end
            if (w_push) begin
                r_received <= r_received + CNT_W'(1);
            end
        end
    end

    // In-flight request count and FIFO bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding <= OCC_W'(0);
            r_occ         <= OCC_W'(0);
            r_wr_ptr      <= PTR_W'(0);
            r_rd_ptr      <= PTR_W'(0);
        end else begin
            case ({w_req_fire, w_push})
                2'b10:   r_outstanding <= r_outstanding + OCC_W'(1);
                2'b01:   r_outstanding <= r_outstanding - OCC_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Buffer storage; contents need no reset because occupancy gates out_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr]      <= resp_data;
            r_last_mem[r_wr_ptr] <= w_push_last;
        end
    end

    assign cmd_ready    = (r_state == S_IDLE);
    assign req_valid    = w_req_valid;
    assign req_is_write = 1'b0;
    assign req_addr     = r_req_addr;
    assign req_size     = BEAT_BYTES;
    assign req_data     = DATA_W'(0);
    assign resp_grant   = resp_valid;
    assign out_valid    = (r_occ != OCC_W'(0));
    assign out_data     = r_mem[r_rd_ptr];
    assign out_last     = out_valid && r_last_mem[r_rd_ptr];
    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;
    assign err          = r_err;

endmodule
